// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock types: BCD digit, minute pair and digit limits.
// Reused by the minute, hour and alarm-compare blocks.
package alarm_clock_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } minute_t;

  localparam bcd_t MIN_TENS_MAX  = 4'd5;
  localparam bcd_t HR_TENS_MAX   = 4'd2;
  localparam bcd_t BCD_DIGIT_MAX = 4'd9;

  function automatic logic bcd_le(input bcd_t d, input bcd_t lim);
    return (d <= lim);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register with load, wrapping increment and carry-out.
// Load wins over increment; any value at or above max wraps to zero on increment.
module bcd_digit
  import alarm_clock_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] q,
  output logic             at_max,
  output logic             carry
);

  bcd_t q_r;

  // digit state: load first, then wrapping increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= 4'd0;
    end else if (ld) begin
      q_r <= ld_val;
    end else if (inc) begin
      if (q_r >= max) begin
        q_r <= 4'd0;
      end else begin
        q_r <= q_r + 4'd1;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q      = q_r;
  assign at_max = (q_r == max);
  assign carry  = inc & at_max;

endmodule

// File: rtl/minute_counter.sv
// BCD minute register 00..TENS_MAX:UNITS_WRAP advanced or loaded by the minute strobe.
// Flags the last minute of the hour and pulses rollover / load_err one cycle after the event.
module minute_counter
  import alarm_clock_pkg::*;
#(
  parameter bcd_t TENS_MAX   = MIN_TENS_MAX,
  parameter bcd_t UNITS_WRAP = 4'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             minute_enable,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_units,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_units,
  output logic             hour_thresh,
  output logic             rollover,
  output logic             load_err
);

  minute_t cur_s;
  logic    load_ok_s;
  logic    illegal_s;
  logic    count_s;
  logic    recover_s;
  logic    digit_ld_s;
  logic    units_inc_s;
  logic    units_carry_s;
  logic    units_at_max_s;
  logic    tens_at_max_s;
  logic    tens_carry_s;
  bcd_t    units_ld_val_s;
  bcd_t    tens_ld_val_s;
  logic    rollover_r;
  logic    load_err_r;

  // strobe decode; a corrupted state is cleared through the load path so both digits reset together
  always_comb begin
    load_ok_s      = bcd_le(load_tens, TENS_MAX) && bcd_le(load_units, BCD_DIGIT_MAX);
    illegal_s      = !bcd_le(cur_s.units, UNITS_WRAP) || !bcd_le(cur_s.tens, TENS_MAX);
    count_s        = minute_enable & ~load;
    recover_s      = count_s & illegal_s;
    units_inc_s    = count_s & ~illegal_s;
    digit_ld_s     = (minute_enable & load & load_ok_s) | recover_s;
    units_ld_val_s = load_units;
    tens_ld_val_s  = load_tens;
    if (recover_s) begin
      units_ld_val_s = 4'd0;
      tens_ld_val_s  = 4'd0;
    end else begin
      units_ld_val_s = load_units;
      tens_ld_val_s  = load_tens;
    end
  end

  bcd_digit u_units (
    .clk    (clk),
    .reset  (reset),
    .inc    (units_inc_s),
    .ld     (digit_ld_s),
    .ld_val (units_ld_val_s),
    .max    (UNITS_WRAP),
    .q      (cur_s.units),
    .at_max (units_at_max_s),
    .carry  (units_carry_s)
  );

  bcd_digit u_tens (
    .clk    (clk),
    .reset  (reset),
    .inc    (units_carry_s),
    .ld     (digit_ld_s),
    .ld_val (tens_ld_val_s),
    .max    (TENS_MAX),
    .q      (cur_s.tens),
    .at_max (tens_at_max_s),
    .carry  (tens_carry_s)
  );

  // event pulses: a tens carry is exactly a legal wrap from the last minute
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rollover_r <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      rollover_r <= tens_carry_s;
      load_err_r <= minute_enable & load & ~load_ok_s;
    end
  end

  assign min_tens    = cur_s.tens;
  assign min_units   = cur_s.units;
  assign hour_thresh = tens_at_max_s & units_at_max_s;
  assign rollover    = rollover_r;
  assign load_err    = load_err_r;

endmodule

// File: tb/tb_minute_counter.sv
// Scoreboard bench for minute_counter: a reference model pushes the expected
// outputs per driven cycle, popped and compared one edge later.
module tb_minute_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       minute_enable;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_units;
  logic [3:0] min_tens;
  logic [3:0] min_units;
  logic       hour_thresh;
  logic       rollover;
  logic       load_err;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
    logic       ht;
    logic       ro;
    logic       le;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_tens   = 4'd0;
  logic [3:0] m_units  = 4'd0;

  minute_counter dut (
    .clk           (clk),
    .reset         (reset),
    .minute_enable (minute_enable),
    .load          (load),
    .load_tens     (load_tens),
    .load_units    (load_units),
    .min_tens      (min_tens),
    .min_units     (min_units),
    .hour_thresh   (hour_thresh),
    .rollover      (rollover),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("min_tens",    {28'd0, min_tens},    {28'd0, e.tens});
      check("min_units",   {28'd0, min_units},   {28'd0, e.units});
      check("hour_thresh", {31'd0, hour_thresh}, {31'd0, e.ht});
      check("rollover",    {31'd0, rollover},    {31'd0, e.ro});
      check("load_err",    {31'd0, load_err},    {31'd0, e.le});
    end
  endtask

  // one clock: drive at negedge, model the result, compare after the posedge
  task automatic step(input logic en, input logic ld, input logic [3:0] lt, input logic [3:0] lu);
    exp_t e;
    logic ro;
    logic le;
    @(negedge clk);
    minute_enable = en;
    load          = ld;
    load_tens     = lt;
    load_units    = lu;
    ro = 1'b0;
    le = 1'b0;
    if (en) begin
      if (ld) begin
        if (lt <= 4'd5 && lu <= 4'd9) begin
          m_tens  = lt;
          m_units = lu;
        end else begin
          le = 1'b1;
        end
      end else if (m_units > 4'd9 || m_tens > 4'd5) begin
        m_tens  = 4'd0;
        m_units = 4'd0;
      end else if (m_units < 4'd9) begin
        m_units = m_units + 4'd1;
      end else if (m_tens < 4'd5) begin
        m_units = 4'd0;
        m_tens  = m_tens + 4'd1;
      end else begin
        m_units = 4'd0;
        m_tens  = 4'd0;
        ro      = 1'b1;
      end
    end
    e.tens  = m_tens;
    e.units = m_units;
    e.ht    = (m_tens == 4'd5) && (m_units == 4'd9);
    e.ro    = ro;
    e.le    = le;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    reset = 1'b1;
    minute_enable = 1'b0;
    load = 1'b0;
    load_tens = 4'd0;
    load_units = 4'd0;
    #12;
    check("rst_tens",  {28'd0, min_tens},  32'd0);
    check("rst_units", {28'd0, min_units}, 32'd0);
    check("rst_ht",    {31'd0, hour_thresh}, 32'd0);
    check("rst_ro",    {31'd0, rollover},  32'd0);
    check("rst_le",    {31'd0, load_err},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 4'd0, 4'd0);

    // 60 spaced strobes: full hour back to 00
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0);
      step(1'b0, 1'b0, 4'd0, 4'd0);
      step(1'b0, 1'b0, 4'd0, 4'd0);
    end

    // back-to-back strobes across the wrap
    step(1'b1, 1'b1, 4'd5, 4'd5);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0);

    // valid load to 59 then count
    step(1'b1, 1'b1, 4'd4, 4'd2);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd5, 4'd9);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0);

    // invalid loads and load without strobe
    step(1'b1, 1'b1, 4'd1, 4'd7);
    step(1'b1, 1'b1, 4'd6, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd2, 4'hA);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 4'd2, 4'd3);
    step(1'b0, 1'b0, 4'd0, 4'd0);

    // corrupted units digit recovers on the next count strobe
    force dut.u_units.q_r = 4'hC;
    #1;
    release dut.u_units.q_r;
    m_units = 4'hC;
    check("forced_units", {28'd0, min_units}, 32'hC);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0);

    // asynchronous reset mid-run while load_err is high
    step(1'b1, 1'b1, 4'd3, 4'd7);
    step(1'b1, 1'b1, 4'd7, 4'd7);
    #2;
    reset = 1'b1;
    #1;
    m_tens  = 4'd0;
    m_units = 4'd0;
    check("arst_tens",  {28'd0, min_tens},  32'd0);
    check("arst_units", {28'd0, min_units}, 32'd0);
    check("arst_ro",    {31'd0, rollover},  32'd0);
    check("arst_le",    {31'd0, load_err},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    minute_enable = 1'b0;
    load = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/minute_counter.md
Name: minute_counter

Overview:
- BCD minute register for the alarm clock, directly downstream of the minute-enable stage.
- Consumes the one-cycle `minute_enable` strobe. That strobe is (seconds threshold AND run enable) OR loader.
- On each strobe it either increments 00..59 or loads a user-set value.
- Produces the minute digits for display/alarm compare, and the `hour_thresh` flag that feeds the hour-enable stage.

Parameters:
- TENS_MAX, 5, largest legal tens digit; wrap point is TENS_MAX:UNITS_WRAP.
- UNITS_WRAP, 9, largest units digit reached before tens increments.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- minute_enable  input  1  single-cycle strobe from the minute-enable stage; qualifies every state change
- load  input  1  when high with minute_enable, strobe is a load, not a count
- load_tens  input  4  BCD tens value to load
- load_units  input  4  BCD units value to load
- min_tens  output  4  current tens digit, registered
- min_units  output  4  current units digit, registered
- hour_thresh  output  1  combinational: high while count == TENS_MAX:UNITS_WRAP
- rollover  output  1  registered one-cycle pulse in the cycle after a wrap to 00
- load_err  output  1  registered one-cycle pulse in the cycle after a rejected load

Behaviour:
- Reset (async assert, any time, including mid-count): min_tens=0, min_units=0, rollover=0, load_err=0. hour_thresh follows the count, so it is 0.
- Only minute_enable qualifies updates. With minute_enable=0, digits hold and rollover/load_err are 0, regardless of load.
- Count (minute_enable=1, load=0), one-cycle latency; new digits are visible the next cycle:
  - units < UNITS_WRAP: units+1.
  - units == UNITS_WRAP and tens < TENS_MAX: units=0, tens+1.
  - units == UNITS_WRAP and tens == TENS_MAX: tens=0, units=0, rollover=1 for exactly one cycle.
- Load (minute_enable=1, load=1), with load taking priority over count in the same cycle:
  - Valid when load_tens <= TENS_MAX and load_units <= 9. The digits take the load values next cycle; no rollover even if loading 00.
  - Invalid: digits hold, load_err=1 for one cycle.
- Out-of-range state (units > 9 or tens > TENS_MAX, unreachable except via SEU/X): the next count strobe forces 00. Recovery needs no reset.
- hour_thresh is combinational from the registered digits, with no strobe gating. The downstream hour stage ANDs it with its own enable, mirroring the minute stage. It stays high for the whole :59 minute.
- Back-to-back strobes on consecutive cycles are legal; each advances once.
- rollover and load_err are never high in the same cycle.
- No internal FSM beyond the two BCD digit counters. Mode is decided per strobe by load.

Decomposition:
- Shared package alarm_clock_pkg:
  - BCD_W=4
  - MIN_TENS_MAX=5, HR_TENS_MAX=2
  - typedef of a BCD digit
  - typedef of a minute struct {tens, units}, reused by the hour and alarm-compare blocks
- One sub-module, bcd_digit:
  - Ports: clk, reset, inc, ld, ld_val, max.
  - Outputs: q, at_max (q == max), carry.
- minute_counter instantiates two bcd_digit instances:
  - units with max=UNITS_WRAP.
  - tens with max=TENS_MAX, inc = unit carry.
- Validity check, rollover and load_err registers live in the top.

Test Plan:
- Reset mid-run: count at 3:7, assert reset asynchronously between edges -> digits 0:0 immediately, rollover=0, load_err=0; release -> holds 0:0 without strobes.
- Counting: 60 strobes from 00, one every 3 cycles -> sequence 00,01..09,10..59,00; hour_thresh high only at 59; rollover pulse exactly once, one cycle after the 59->00 edge.
- Consecutive strobes: minute_enable high 12 consecutive cycles from 55 -> 56,57,58,59,00,01..07; rollover one cycle wide.
- Valid load: at 42, minute_enable=1, load=1, load=5:9 -> next cycle 59, hour_thresh=1, rollover=0; next count strobe -> 00 with rollover.
- Invalid load: at 17, load 6:0, then load 2:A -> digits stay 17, load_err pulses once per attempt; load=1 with minute_enable=0 -> no change, no error.
- Forced illegal state (force units=4'hC, release): next count strobe -> 00, no rollover.
